// File: rtl/ds1302_pkg.sv
// Shared constants for the DS1302-compatible 3-wire responder: FSM encoding,
// clock register map, reset values and the BCD step helper.
package ds1302_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CMD   = 3'd1;
    localparam logic [2:0] ST_WDATA = 3'd2;
    localparam logic [2:0] ST_RDATA = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam logic [2:0] REG_SEC  = 3'd0;
    localparam logic [2:0] REG_MIN  = 3'd1;
    localparam logic [2:0] REG_HR   = 3'd2;
    localparam logic [2:0] REG_DATE = 3'd3;
    localparam logic [2:0] REG_MON  = 3'd4;
    localparam logic [2:0] REG_DAY  = 3'd5;
    localparam logic [2:0] REG_YEAR = 3'd6;
    localparam logic [2:0] REG_CTRL = 3'd7;

    localparam logic [7:0] SEC_RST     = 8'h80;
    localparam logic [7:0] CTRL_RST    = 8'h80;
    localparam logic [7:0] CMD_CTRL_WR = 8'h8E;
    localparam logic [4:0] CMD_BURST   = 5'd31;

    // Returns {wrap, next} for a two-digit BCD counter that wraps to 00 after 'last'.
    function automatic logic [7:0] bcd_step(input logic [6:0] v, input logic [6:0] last);
        logic [7:0] r;
        if (v == last) begin
            r = 8'h00;
            r[7] = 1'b1;
        end else if (v[3:0] == 4'd9) begin
            r = {1'b0, v[6:4] + 3'd1, 4'd0};
        end else begin
            r = {1'b0, v[6:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

endpackage

// File: rtl/ds1302_pin_sync.sv
// Synchronizes the 3-wire pins into the sclk domain and detects serial clock edges.
module ds1302_pin_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic sclk,
    input  logic nrst,
    input  logic i_ce,
    input  logic i_sclk,
    input  logic i_io,
    output logic o_ce,
    output logic o_io,
    output logic o_rise,
    output logic o_fall,
    output logic o_valid
);

    logic [SYNC_STAGES-1:0] r_ce;
    logic [SYNC_STAGES-1:0] r_sck;
    logic [SYNC_STAGES-1:0] r_io;
    logic [SYNC_STAGES-1:0] r_fill;
    logic                   r_sck_prev;

    always_ff @(posedge sclk or negedge nrst) begin
        if (!nrst) begin
            r_ce       <= '0;
            r_sck      <= '0;
            r_io       <= '0;
            r_fill     <= '0;
            r_sck_prev <= 1'b0;
        end else begin
            r_ce[0]    <= i_ce;
            r_sck[0]   <= i_sclk;
            r_io[0]    <= i_io;
            r_fill[0]  <= 1'b1;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_ce[i]   <= r_ce[i-1];
                r_sck[i]  <= r_sck[i-1];
                r_io[i]   <= r_io[i-1];
                r_fill[i] <= r_fill[i-1];
            end
            r_sck_prev <= r_sck[SYNC_STAGES-1];
        end
    end

    assign o_ce    = r_ce[SYNC_STAGES-1];
    assign o_io    = r_io[SYNC_STAGES-1];
    assign o_rise  = r_sck[SYNC_STAGES-1] & ~r_sck_prev;
    assign o_fall  = ~r_sck[SYNC_STAGES-1] & r_sck_prev;
    // Synchronizer outputs are only trustworthy once reset zeros have flushed through.
    assign o_valid = r_fill[SYNC_STAGES-1];

endmodule

// File: rtl/ds1302_responder.sv
// DS1302-style 3-wire slave: command/data shifter, clock/control registers,
// scratch RAM and a seconds/minutes/hours BCD timekeeper.
module ds1302_responder
    import ds1302_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned RAM_DEPTH   = 31
) (
    input  logic       sclk,
    input  logic       nrst,
    input  logic       ds_ce,
    input  logic       ds_sclk,
    inout  wire        ds_io,
    input  logic       sec_tick,
    output logic       wr_strobe,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data
);

    logic       w_ce, w_io, w_rise, w_fall, w_sync_valid;
    logic [2:0] r_state;
    logic [7:0] r_shift, r_cmd;
    logic [3:0] r_cnt;
    logic       r_oe, r_out, r_armed;
    logic       r_wr_strobe;
    logic [7:0] r_wr_addr, r_wr_data;
    logic [7:0] r_clk [8];
    logic [7:0] r_ram [RAM_DEPTH];

    logic [7:0] w_cmd_byte;
    logic [6:1] w_sel;
    logic       w_sel_ok, w_commit, w_wr_clk;
    logic [7:0] w_rd_byte;
    logic [7:0] w_sec_step, w_min_step, w_hr_step;
    logic       w_tick_sec, w_tick_min, w_tick_hr;

    ds1302_pin_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_pin_sync (
        .sclk    (sclk),
        .nrst    (nrst),
        .i_ce    (ds_ce),
        .i_sclk  (ds_sclk),
        .i_io    (ds_io),
        .o_ce    (w_ce),
        .o_io    (w_io),
        .o_rise  (w_rise),
        .o_fall  (w_fall),
        .o_valid (w_sync_valid)
    );

    assign w_cmd_byte = {w_io, r_shift[7:1]};

    always_comb begin
        w_sel     = (r_state == ST_CMD) ? w_cmd_byte[6:1] : r_cmd[6:1];
        w_sel_ok  = w_sel[6] ? (32'(w_sel[5:1]) < RAM_DEPTH) : !w_sel[4];
        w_rd_byte = 8'h00;
        if (w_sel_ok) begin
            w_rd_byte = w_sel[6] ? r_ram[w_sel[5:1]] : r_clk[w_sel[3:1]];
        end
        w_commit = (r_state == ST_WDATA) && w_ce && w_rise && (r_cnt == 4'd7) && w_sel_ok
                   && (!r_clk[REG_CTRL][7] || r_cmd == CMD_CTRL_WR);
        w_wr_clk = w_commit && !r_cmd[6];
    end

    // A register being written this cycle swallows any carry out of it.
    always_comb begin
        w_sec_step = bcd_step(r_clk[REG_SEC][6:0], 7'h59);
        w_min_step = bcd_step(r_clk[REG_MIN][6:0], 7'h59);
        w_hr_step  = bcd_step({1'b0, r_clk[REG_HR][5:0]}, 7'h23);
        w_tick_sec = sec_tick && !r_clk[REG_SEC][7];
        w_tick_min = w_tick_sec && w_sec_step[7] && !(w_wr_clk && r_cmd[3:1] == REG_SEC);
        w_tick_hr  = w_tick_min && w_min_step[7] && !(w_wr_clk && r_cmd[3:1] == REG_MIN);
    end

    always_ff @(posedge sclk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < 8; i++) r_clk[i] <= 8'h00;
            r_clk[REG_SEC]  <= SEC_RST;
            r_clk[REG_CTRL] <= CTRL_RST;
            for (int i = 0; i < int'(RAM_DEPTH); i++) r_ram[i] <= 8'h00;
        end else begin
            if (w_tick_sec) r_clk[REG_SEC] <= {1'b0, w_sec_step[6:0]};
            if (w_tick_min) r_clk[REG_MIN] <= {r_clk[REG_MIN][7], w_min_step[6:0]};
            if (w_tick_hr)  r_clk[REG_HR]  <= {r_clk[REG_HR][7], w_hr_step[6:0]};
            if (w_commit) begin
                if (!r_cmd[6]) begin
                    r_clk[r_cmd[3:1]] <= (r_cmd[3:1] == REG_CTRL) ?
                                         {w_cmd_byte[7], 7'd0} : w_cmd_byte;
                end else begin
                    r_ram[r_cmd[5:1]] <= w_cmd_byte;
                end
            end
        end
    end

    always_ff @(posedge sclk or negedge nrst) begin
        if (!nrst) begin
            r_state     <= ST_IDLE;
            r_shift     <= 8'h00;
            r_cmd       <= 8'h00;
            r_cnt       <= 4'd0;
            r_oe        <= 1'b0;
            r_out       <= 1'b0;
            r_armed     <= 1'b0;
            r_wr_strobe <= 1'b0;
            r_wr_addr   <= 8'h00;
            r_wr_data   <= 8'h00;
        end else begin
            r_wr_strobe <= w_commit;
            if (w_commit) begin
                r_wr_addr <= r_cmd;
                r_wr_data <= w_cmd_byte;
            end
            // A frame may only start after ce has been seen low since reset.
            if (w_sync_valid && !w_ce) r_armed <= 1'b1;
            if (!w_ce) begin
                r_state <= ST_IDLE;
                r_oe    <= 1'b0;
                r_cnt   <= 4'd0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state <= r_armed ? ST_CMD : ST_DONE;
                        r_cnt   <= 4'd0;
                    end
                    ST_CMD: if (w_rise) begin
                        r_shift <= w_cmd_byte;
                        r_cnt   <= r_cnt + 4'd1;
                        if (r_cnt == 4'd7) begin
                            r_cnt <= 4'd0;
                            r_cmd <= w_cmd_byte;
                            if (!w_cmd_byte[7] || w_cmd_byte[5:1] == CMD_BURST) begin
                                r_state <= ST_DONE;
                            end else if (!w_cmd_byte[0]) begin
                                r_state <= ST_WDATA;
                            end else begin
                                r_state <= ST_RDATA;
                                r_shift <= w_rd_byte;
                            end
                        end
                    end
                    ST_WDATA: if (w_rise) begin
                        r_shift <= w_cmd_byte;
                        r_cnt   <= r_cnt + 4'd1;
                        if (r_cnt == 4'd7) r_state <= ST_DONE;
                    end
                    ST_RDATA: if (w_fall) begin
                        if (r_cnt == 4'd8) begin
                            r_oe    <= 1'b0;
                            r_state <= ST_DONE;
                        end else begin
                            r_oe    <= 1'b1;
                            r_out   <= r_shift[0];
                            r_shift <= {1'b0, r_shift[7:1]};
                            r_cnt   <= r_cnt + 4'd1;
                        end
                    end
                    ST_DONE: r_oe <= 1'b0;
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign ds_io     = r_oe ? r_out : 1'bz;
    assign wr_strobe = r_wr_strobe;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;

endmodule

// File: doc/ds1302_responder.md
DS1302_RESPONDER -- requirements
Module: ds1302_responder

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchronizer depth for ds_ce and ds_sclk, and for the ds_io input.
REQ-002 Parameter RAM_DEPTH, default 31: number of scratch RAM bytes, 1..31.
REQ-003 sclk  in  1  system clock; nrst  in  1  reset, asynchronous, active-low.
REQ-004 ds_ce  in  1  chip enable driven by the 3-wire master.
REQ-005 ds_sclk  in  1  serial clock driven by the master.
REQ-006 ds_io  inout  1  serial data, LSB first; high-Z unless this block is driving read data.
REQ-007 sec_tick  in  1  one-sclk pulse, nominally 1 Hz, that advances the timekeeper.
REQ-008 wr_strobe  out  1  one-cycle pulse when a write commits.
REQ-009 wr_addr  out  8  command byte of the committed write.
REQ-010 wr_data  out  8  data byte of the committed write.

Function
REQ-011 The block SHALL sample ds_ce, ds_sclk and ds_io through SYNC_STAGES flops and SHALL detect rising and falling ds_sclk edges on the synchronized signal.
REQ-012 The FSM SHALL have the states IDLE, CMD, WDATA, RDATA and DONE.
  - Synchronized ds_ce low forces IDLE from any state.
  - IDLE goes to CMD when ds_ce is high.
REQ-013 In CMD, the block SHALL shift ds_io in on each rising edge, bit0 first, until bits 0..7 form the command.
REQ-014 After the 8th rising edge, the command SHALL be decoded as follows.
  - cmd[7]=0: go to DONE.
  - cmd[5:1]=31 (burst): go to DONE; burst mode is unsupported.
  - cmd[0]=0: go to WDATA.
  - cmd[0]=1: go to RDATA.
REQ-015 Address mapping: cmd[6]=0 selects clock register cmd[3:1]; cmd[4] SHALL be 1'b0 for clock accesses, otherwise the access is ignored. cmd[6]=1 selects RAM index cmd[5:1]; an index >= RAM_DEPTH is ignored.
REQ-016 In WDATA, the block SHALL shift 8 bits on rising edges.
  - On the 8th data rising edge, commit the write and pulse wr_strobe one cycle later with wr_addr and wr_data; then go to DONE.
  - A write to an ignored address produces no commit and no strobe.
REQ-017 Write protect is control register bit7 (WP).
  - While WP=1, writes to every address except the control register (cmd 0x8E) SHALL be dropped, with no wr_strobe.
  - The control register stores bit7 only; bits 6:0 read as 0.
REQ-018 In RDATA, the block SHALL snapshot the addressed byte at the 8th command rising edge.
  - Drive bit0 after the next falling edge, then one further bit after each subsequent falling edge.
  - Release ds_io on the falling edge after bit7 is driven, then go to DONE.
  - An ignored address reads 0x00.
REQ-019 DONE SHALL ignore all ds_sclk edges and keep ds_io high-Z until ds_ce goes low.
REQ-020 ds_ce falling mid-frame SHALL abort the frame: no commit, ds_io released within SYNC_STAGES+1 cycles.
REQ-021 Clock register 0 bit7 is CH (clock halt). On sec_tick with CH=0, the block SHALL advance the BCD counters.
  - Seconds count 00..59 and carry into minutes on wrap.
  - Minutes count 00..59 and carry into hours on wrap.
  - Hours count 00..23 in 24-hour mode only; hours bit7 is stored but does not affect counting.
REQ-022 If a write commit and sec_tick occur in the same cycle, the written register SHALL take the written value, and no carry SHALL propagate out of it that cycle.
REQ-023 Clock registers 3..6 (date, month, day, year) SHALL be plain storage with no calendar counting.

Reset
REQ-024 On nrst low, the block SHALL apply these values asynchronously:
  - FSM = IDLE; ds_io high-Z.
  - wr_strobe=0, wr_addr=0x00, wr_data=0x00.
  - Seconds=0x80 (CH=1); control=0x80 (WP=1).
  - All other clock registers = 0x00; RAM = 0x00.
  - Synchronizers and shift registers cleared.
REQ-025 Release of nrst while ds_ce is high SHALL wait in DONE until ds_ce goes low.

Structure
REQ-026 Package ds1302_pkg SHALL hold:
  - the FSM state enumeration;
  - the clock register indices (SEC=0 .. CTRL=7);
  - the reset values 0x80/0x80;
  - the CMD_BURST=31 constant.
REQ-027 One sub-module, ds1302_pin_sync, SHALL implement the synchronizers and ds_sclk edge detection.

Verification
REQ-028 Reset, then read 0x81: 0x80 is returned LSB first; ds_io is high-Z after bit7.
REQ-029 Write 0x8E=0x00, then write 0x80=0x25, then read 0x81: wr_strobe pulses twice (0x8E/0x00, 0x80/0x25); the read returns 0x25.
REQ-030 With WP=1 after reset, write 0x84=0x12, then read 0x85: no wr_strobe; the read returns 0x00.
REQ-031 With WP=0, set seconds=0x59, minutes=0x59, hours=0x23, then apply one sec_tick: the three registers read 0x00, 0x00, 0x00.
REQ-032 With WP=0, write 0xC0=0xAA but drop ds_ce after 12 rising edges: no strobe; a read of 0xC1 returns 0x00; ds_io is high-Z throughout.
REQ-033 Send command 0x41 (cmd[7]=0) plus 8 clocks: ds_io stays high-Z; no strobe; the FSM stays in DONE until ds_ce goes low.
